// File: rtl/wb_sram16_ctrl.sv
// Wishbone slave for a 16-bit asynchronous SRAM: each 32-bit access becomes two
// half-word strobes (even half = wb_dat[31:16]) with programmable strobe width.
module wb_sram16_ctrl #(
    parameter int adr_width = 18,
    parameter int latency   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o,
    output logic [adr_width-1:0] sram_adr,
    inout  logic [15:0]          sram_dat,
    output logic [1:0]           sram_be_n,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [2:0]           o_dbg_state
);

    localparam int CW = (latency > 1) ? $clog2(latency) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(latency - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H0   = 3'd1,
        S_GAP0 = 3'd2,
        S_H1   = 3'd3,
        S_GAP1 = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [adr_width-2:0]  r_word;
    logic [31:0]           r_wdat;
    logic [3:0]            r_sel;
    logic                  r_we;
    logic                  r_abort;

    logic [adr_width-1:0]  r_sram_adr;
    logic [15:0]           r_dout;
    logic                  r_drive;
    logic [1:0]            r_be_n;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic                  r_ack;
    logic [31:0]           r_dat_o;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_we;
    logic [3:0]            w_sel;
    logic [31:0]           w_wdat;
    logic [adr_width-2:0]  w_word;
    logic                  w_abort;
    logic                  w_last;
    logic                  w_in_h;
    logic                  w_in_seq;
    logic                  w_odd;
    logic [1:0]            w_pair;
    logic [32-adr_width:0] w_unused;

    assign w_unused = {wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_accept = (r_state == S_IDLE) & w_req;
    // Request fields are used directly on the accepting edge so strobes start with the state.
    assign w_we     = w_accept ? wb_we_i  : r_we;
    assign w_sel    = w_accept ? wb_sel_i : r_sel;
    assign w_wdat   = w_accept ? wb_dat_i : r_wdat;
    assign w_word   = w_accept ? wb_adr_i[adr_width:2] : r_word;
    assign w_abort  = r_abort | ~wb_cyc_i;
    assign w_last   = (r_cnt == '0);

    assign w_in_h   = (w_next == S_H0) | (w_next == S_H1);
    assign w_in_seq = w_in_h | (w_next == S_GAP0) | (w_next == S_GAP1);
    assign w_odd    = (w_next == S_H1) | (w_next == S_GAP1);
    assign w_pair   = w_odd ? w_sel[1:0] : w_sel[3:2];

    // A skipped write half still costs one gap cycle, keeping single-half writes at a fixed length.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!wb_we_i)                 w_next = S_H0;
                    else if (wb_sel_i == 4'b0000) w_next = S_ACK;
                    else if (wb_sel_i[3:2] == 2'b00) w_next = S_GAP0;
                    else                          w_next = S_H0;
                end
            end
            S_H0:   if (w_last) w_next = S_GAP0;
            S_GAP0: w_next = (r_we && r_sel[1:0] == 2'b00) ? S_GAP1 : S_H1;
            S_H1:   if (w_last) w_next = S_GAP1;
            S_GAP1: w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_word     <= '0;
            r_wdat     <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_abort    <= 1'b0;
            r_sram_adr <= '0;
            r_dout     <= '0;
            r_drive    <= 1'b0;
            r_be_n     <= 2'b11;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)  r_cnt <= CNT_LOAD;
            else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;

            if (w_accept) begin
                r_word <= wb_adr_i[adr_width:2];
                r_wdat <= wb_dat_i;
                r_sel  <= wb_sel_i;
                r_we   <= wb_we_i;
            end
            r_abort <= (w_next == S_IDLE) ? 1'b0 : w_abort;

            r_ce_n  <= ~w_in_seq;
            r_oe_n  <= ~(w_in_h & ~w_we);
            r_we_n  <= ~(w_in_h & w_we);
            r_be_n  <= !w_in_seq ? 2'b11 : (w_we ? ~w_pair : 2'b00);
            r_drive <= w_in_seq & w_we;
            if (w_in_seq) begin
                r_sram_adr <= {w_word, w_odd};
                r_dout     <= w_odd ? w_wdat[15:0] : w_wdat[31:16];
            end
            r_ack <= (w_next == S_ACK) & ~w_abort;

            if (!r_we && w_last) begin
                if (r_state == S_H0)      r_dat_o[31:16] <= sram_dat;
                else if (r_state == S_H1) r_dat_o[15:0]  <= sram_dat;
            end
        end
    end

    assign sram_dat    = r_drive ? r_dout : 16'hzzzz;
    assign sram_adr    = r_sram_adr;
    assign sram_be_n   = r_be_n;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat_o;
    assign o_dbg_state = r_state;

endmodule
